// File: rtl/half_pkg.sv
// Shared definitions for the halved-sample expander: widths, mode codes,
// header payload and the reconstruction function (also used by encoder models).
package half_pkg;

  localparam int unsigned Q_W   = 4;
  localparam int unsigned X_W   = 5;
  localparam int unsigned IDX_W = 2;

  localparam logic MODE_FLOOR = 1'b0;
  localparam logic MODE_CEIL  = 1'b1;

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  typedef struct packed {
    logic [Q_W-1:0] res;
    logic           mode;
  } hdr_t;

  // x = 2q +/- r, wrapping modulo 2^X_W; {q,0} is the sign-extended 2q.
  function automatic logic [X_W-1:0] recon(input logic [Q_W-1:0] q,
                                           input logic           r,
                                           input logic           m);
    logic [X_W-1:0] dbl;
    dbl = {q, 1'b0};
    return (m == MODE_CEIL) ? dbl - X_W'(r) : dbl + X_W'(r);
  endfunction

endpackage

// File: rtl/half_out_slot.sv
// Single-entry registered valid/ready output slot, no bypass path.
module half_out_slot
  import half_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic [X_W-1:0] load_data_i,
  input  logic           out_ready_i,
  output logic           out_valid_o,
  output logic [X_W-1:0] out_data_o
);

  logic           valid_q, valid_d;
  logic [X_W-1:0] data_q, data_d;

  // A load wins over a drain; data holds otherwise.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/half_expand.sv
// Framed nibble decoder: one residual header nibble then FRAME_LEN quotient
// nibbles, each rebuilt into a 5-bit signed sample.
module half_expand
  import half_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sof,
  input  logic [Q_W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [X_W-1:0] out_data,
  output logic           frame_err
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  hdr_t             hdr_q, hdr_d;
  logic             err_q, err_d;
  logic             live_q;
  logic             acc_c;
  logic             load_c;
  logic [X_W-1:0]   x_c;

  // Headers never fill the slot, so they are always accepted once out of reset.
  assign in_ready = live_q & ((state_q == ST_HDR) | ~out_valid | out_ready);
  assign acc_c    = in_valid & in_ready;
  assign x_c      = recon(in_data, hdr_q.res[idx_q], hdr_q.mode);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hdr_d   = hdr_q;
    err_d   = 1'b0;
    load_c  = 1'b0;
    if (acc_c) begin
      if (in_sof) begin
        // A header inside DATA abandons the old frame and restarts.
        hdr_d   = '{res: in_data, mode: mode};
        idx_d   = '0;
        state_d = ST_DATA;
        err_d   = (state_q == ST_DATA);
      end else if (state_q == ST_HDR) begin
        err_d = 1'b1;
      end else begin
        load_c = 1'b1;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(FRAME_LEN - 1)) state_d = ST_HDR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HDR;
      idx_q   <= '0;
      hdr_q   <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hdr_q   <= hdr_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  assign frame_err = err_q;

  half_out_slot u_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_c),
    .load_data_i (x_c),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data)
  );

endmodule

// File: tb/tb_half_expand.sv
// Directed bench for half_expand: framing, both halving modes, backpressure,
// framing errors and asynchronous reset.
module tb_half_expand;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic       in_sof;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  half_expand #(.FRAME_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat, wait (bounded) for acceptance, return 1 time unit after the edge.
  task automatic beat(input logic sof, input logic [3:0] d);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    in_data = 4'h0; out_ready = 1'b1;
    #2;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 5'h00 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: rdy=%0b vld=%0b data=%h err=%0b required 0 0 00 0",
               in_ready, out_valid, out_data, frame_err);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_floor();
    logic [3:0] qv[4];
    logic [4:0] xv[4];
    qv = '{4'd3, 4'hE, 4'd7, 4'h8};
    xv = '{5'd7, 5'h1C, 5'd15, 5'h10};
    mode = 1'b0; out_ready = 1'b1;
    beat(1'b1, 4'b0101);
    n_cmp++;
    if (out_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL floor_header: vld=%0b err=%0b required 0 0", out_valid, frame_err);
    end
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, qv[i]);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== xv[i] || frame_err !== 1'b0) begin
        n_bad++;
        $display("FAIL floor_sample%0d: vld=%0b data=%h err=%0b required 1 %h 0",
                 i, out_valid, out_data, frame_err, xv[i]);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL floor_drain: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_ceil_wrap();
    logic [3:0] qv[4];
    logic [4:0] xv[4];
    qv = '{4'h8, 4'h0, 4'h0, 4'h0};
    xv = '{5'd15, 5'd0, 5'd0, 5'd0};
    mode = 1'b1; out_ready = 1'b1;
    beat(1'b1, 4'b0001);
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, qv[i]);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== xv[i]) begin
        n_bad++;
        $display("FAIL ceil_wrap%0d: vld=%0b data=%h required 1 %h", i, out_valid, out_data, xv[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [3:0]        hdr;
    logic [3:0]        qs[4];
    logic signed [4:0] xs, t, sh;
    out_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int f = 0; f < 8; f++) begin
        for (int k = 0; k < 4; k++) begin
          xs     = 5'(4 * f + k - 16);
          t      = (m == 1) ? xs + 5'sd1 : xs;
          sh     = t >>> 1;
          qs[k]  = sh[3:0];
          hdr[k] = xs[0];
        end
        mode = m[0];
        beat(1'b1, hdr);
        mode = ~m[0];
        for (int k = 0; k < 4; k++) begin
          beat(1'b0, qs[k]);
          xs = 5'(4 * f + k - 16);
          n_cmp++;
          if (out_valid !== 1'b1 || out_data !== xs) begin
            n_bad++;
            $display("FAIL sweep m=%0d x=%0d: vld=%0b data=%h required 1 %h",
                     m, xs, out_valid, out_data, xs);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; out_ready = 1'b1;
    beat(1'b1, 4'b1010);
    beat(1'b0, 4'd1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 5'd2) begin
      n_bad++;
      $display("FAIL bp_first: vld=%0b data=%h required 1 02", out_valid, out_data);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_sof = 1'b0; in_data = 4'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 5'd2) begin
        n_bad++;
        $display("FAIL bp_stall%0d: rdy=%0b vld=%0b data=%h required 0 1 02",
                 c, in_ready, out_valid, out_data);
      end
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_resume_ready: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 5'd5) begin
      n_bad++;
      $display("FAIL bp_second: vld=%0b data=%h required 1 05", out_valid, out_data);
    end
    beat(1'b0, 4'hF);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 5'h1E) begin
      n_bad++;
      $display("FAIL bp_third: vld=%0b data=%h required 1 1e", out_valid, out_data);
    end
    beat(1'b0, 4'd4);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 5'd9) begin
      n_bad++;
      $display("FAIL bp_fourth: vld=%0b data=%h required 1 09", out_valid, out_data);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_no_dup: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_premature();
    logic [3:0] qv[4];
    logic [4:0] xv[4];
    qv = '{4'd2, 4'hE, 4'd3, 4'hC};
    xv = '{5'd4, 5'h1C, 5'd5, 5'h17};
    mode = 1'b0; out_ready = 1'b1;
    beat(1'b1, 4'b0011);
    beat(1'b0, 4'd1);
    n_cmp++;
    if (out_data !== 5'd3 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_old0: data=%h err=%0b required 03 0", out_data, frame_err);
    end
    beat(1'b0, 4'hD);
    n_cmp++;
    if (out_data !== 5'h1B || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_old1: vld=%0b data=%h required 1 1b", out_valid, out_data);
    end
    mode = 1'b1;
    beat(1'b1, 4'b1100);
    n_cmp++;
    if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_err: err=%0b vld=%0b required 1 0", frame_err, out_valid);
    end
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, qv[i]);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== xv[i] || frame_err !== 1'b0) begin
        n_bad++;
        $display("FAIL pre_new%0d: vld=%0b data=%h err=%0b required 1 %h 0",
                 i, out_valid, out_data, frame_err, xv[i]);
      end
    end
  endtask

  task automatic test_hdr_drop();
    mode = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    beat(1'b0, 4'h7);
    n_cmp++;
    if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_err: err=%0b vld=%0b required 1 0", frame_err, out_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_after: err=%0b vld=%0b required 0 0", frame_err, out_valid);
    end
    beat(1'b1, 4'b0001);
    beat(1'b0, 4'd2);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 5'd5) begin
      n_bad++;
      $display("FAIL drop_next_frame: vld=%0b data=%h required 1 05", out_valid, out_data);
    end
    for (int i = 0; i < 3; i++) beat(1'b0, 4'd0);
  endtask

  task automatic test_async_reset();
    logic [3:0] qv[4];
    logic [4:0] xv[4];
    qv = '{4'd1, 4'd2, 4'd3, 4'hF};
    xv = '{5'd2, 5'd4, 5'd6, 5'h1E};
    mode = 1'b0; out_ready = 1'b1;
    beat(1'b1, 4'hF);
    beat(1'b0, 4'd1);
    beat(1'b0, 4'd2);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 5'd5) begin
      n_bad++;
      $display("FAIL ar_pre: vld=%0b data=%h required 1 05", out_valid, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 5'h00 || in_ready !== 1'b0 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL ar_immediate: vld=%0b data=%h rdy=%0b err=%0b required 0 00 0 0",
               out_valid, out_data, in_ready, frame_err);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1'b1, 4'h0);
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, qv[i]);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== xv[i]) begin
        n_bad++;
        $display("FAIL ar_fresh%0d: vld=%0b data=%h required 1 %h", i, out_valid, out_data, xv[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_floor();
    test_ceil_wrap();
    test_sweep();
    test_backpressure();
    test_premature();
    test_hdr_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
